// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder: word-addressed RAM plus an MMIO page holding a cycle counter,
// a compare timer and a console FIFO drained through a valid/ready port.
module dmem_mmio_responder #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned ADDR_SIZE  = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [ADDR_SIZE-1:0] daddr,
  input  logic [DATA_SIZE-1:0] ddata_w,
  input  logic                 mem_write,
  input  logic                 mem_read,
  output logic [DATA_SIZE-1:0] ddata_r,
  output logic                 timer_irq,
  output logic                 dbg_valid,
  output logic [DATA_SIZE-1:0] dbg_data,
  input  logic                 dbg_ready
);

  localparam int unsigned RamWords = 2 ** ADDR_SIZE - 8;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;

  localparam logic [ADDR_SIZE-1:0] AddrCycle   = ADDR_SIZE'(RamWords);
  localparam logic [ADDR_SIZE-1:0] AddrTimer   = ADDR_SIZE'(RamWords + 1);
  localparam logic [ADDR_SIZE-1:0] AddrStatus  = ADDR_SIZE'(RamWords + 2);
  localparam logic [ADDR_SIZE-1:0] AddrConsole = ADDR_SIZE'(RamWords + 3);

  logic [DATA_SIZE-1:0] r_ram  [RamWords];
  logic [DATA_SIZE-1:0] r_fifo [FIFO_DEPTH];

  logic [DATA_SIZE-1:0] r_cycle;
  logic [DATA_SIZE-1:0] r_timer_cmp;
  logic                 r_pending;
  logic                 r_overflow;
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [DATA_SIZE-1:0] r_last;

  logic                 w_is_ram;
  logic                 w_wr_ram;
  logic                 w_wr_cycle;
  logic                 w_wr_timer;
  logic                 w_wr_status;
  logic                 w_wr_console;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_ovf_set;
  logic                 w_hit;
  logic [DATA_SIZE-1:0] w_rdata;

  assign w_is_ram     = daddr < AddrCycle;
  assign w_wr_ram     = mem_write && w_is_ram;
  assign w_wr_cycle   = mem_write && (daddr == AddrCycle);
  assign w_wr_timer   = mem_write && (daddr == AddrTimer);
  assign w_wr_status  = mem_write && (daddr == AddrStatus);
  assign w_wr_console = mem_write && (daddr == AddrConsole);

  assign w_full    = r_count == CntW'(FIFO_DEPTH);
  assign w_empty   = r_count == '0;
  assign w_pop     = !w_empty && dbg_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign w_push    = w_wr_console && (!w_full || w_pop);
  assign w_ovf_set = w_wr_console && w_full && !w_pop;
  assign w_hit     = r_cycle == r_timer_cmp;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cycle     <= '0;
      r_timer_cmp <= '1;
      r_pending   <= 1'b0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last      <= '0;
    end else begin
      r_cycle <= w_wr_cycle ? ddata_w : r_cycle + DATA_SIZE'(1);
      if (w_wr_timer) r_timer_cmp <= ddata_w;
      // Set wins over write-1-to-clear on both sticky flags.
      r_pending  <= w_hit     | (r_pending  & ~(w_wr_status & ddata_w[0]));
      r_overflow <= w_ovf_set | (r_overflow & ~(w_wr_status & ddata_w[3]));
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_last   <= r_fifo[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
    end
  end

  // Storage arrays are deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (w_wr_ram) r_ram[daddr] <= ddata_w;
    if (w_push)   r_fifo[r_wr_ptr] <= ddata_w;
  end

  always_comb begin
    w_rdata = '0;
    if (mem_read) begin
      if (w_is_ram) begin
        w_rdata = r_ram[daddr];
      end else begin
        unique case (daddr)
          AddrCycle:   w_rdata = r_cycle;
          AddrTimer:   w_rdata = r_timer_cmp;
          AddrStatus:  w_rdata = DATA_SIZE'({r_overflow, w_full, w_empty, r_pending});
          AddrConsole: w_rdata = DATA_SIZE'(r_count);
          default:     w_rdata = '0;
        endcase
      end
    end
  end

  assign ddata_r   = w_rdata;
  assign timer_irq = r_pending;
  assign dbg_valid = !w_empty;
  assign dbg_data  = w_empty ? r_last : r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: scoreboard queues hold expected load data and
// expected console words; each scenario task drives the bus and compares inline.
module tb_dmem_mmio_responder;

  localparam logic [9:0] ACycle   = 10'h3F8;
  localparam logic [9:0] ATimer   = 10'h3F9;
  localparam logic [9:0] AStatus  = 10'h3FA;
  localparam logic [9:0] AConsole = 10'h3FB;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  daddr = '0;
  logic [31:0] ddata_w = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] ddata_r;
  logic        timer_irq;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rdq[$];
  logic [31:0] fifoq[$];
  logic [31:0] exp_v;

  dmem_mmio_responder #(
    .DATA_SIZE (32),
    .ADDR_SIZE (10),
    .FIFO_DEPTH(8)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .daddr    (daddr),
    .ddata_w  (ddata_w),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .ddata_r  (ddata_r),
    .timer_irq(timer_irq),
    .dbg_valid(dbg_valid),
    .dbg_data (dbg_data),
    .dbg_ready(dbg_ready)
  );

  always #5 CLK = ~CLK;

  // One bus cycle: inputs change on the falling edge, outputs are sampled 1 time unit later.
  task automatic drive(input logic [9:0] a, input logic [31:0] d, input logic w, input logic r,
                       input logic rdy);
    @(negedge CLK);
    daddr = a;
    ddata_w = d;
    mem_write = w;
    mem_read = r;
    dbg_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (ddata_r !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", ddata_r); end
    n_cmp++;
    if (timer_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    n_cmp++;
    if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dbg_valid); end
    n_cmp++;
    if (dbg_data !== 32'h0) begin n_err++; $display("FAIL reset_dbgdata: got %h want 0", dbg_data); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    daddr = ACycle;
    mem_read = 1'b1;
    rdq.push_back(32'h0);
    #1;
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL first_cycle: got %h want %h", ddata_r, exp_v); end
  endtask

  task automatic test_ram();
    drive(10'h010, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    rdq.push_back(32'hDEADBEEF);
    drive(10'h010, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL ram_read: got %h want %h", ddata_r, exp_v); end
    drive(10'h3FD, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    rdq.push_back(32'h0);
    drive(10'h3FD, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL reserved_read: got %h want %h", ddata_r, exp_v); end
    drive(10'h010, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ddata_r !== 32'h0) begin n_err++; $display("FAIL no_read_zero: got %h want 0", ddata_r); end
    drive(10'h011, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    rdq.push_back(32'h0000_0001);
    drive(10'h011, 32'h0000_0002, 1'b1, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL rw_same_cycle: got %h want %h", ddata_r, exp_v); end
    rdq.push_back(32'h0000_0002);
    drive(10'h011, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL rw_after: got %h want %h", ddata_r, exp_v); end
  endtask

  task automatic test_cycle();
    drive(ACycle, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    rdq.push_back(32'hFFFF_FFFE);
    rdq.push_back(32'hFFFF_FFFF);
    rdq.push_back(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      drive(ACycle, 32'h0, 1'b0, 1'b1, 1'b0);
      exp_v = rdq.pop_front();
      n_cmp++;
      if (ddata_r !== exp_v) begin
        n_err++;
        $display("FAIL cycle_wrap[%0d]: got %h want %h", i, ddata_r, exp_v);
      end
    end
    // 0xFFFFFFFF matched the reset compare value on the previous edge.
    n_cmp++;
    if (timer_irq !== 1'b1) begin n_err++; $display("FAIL irq_at_reset_cmp: got %b want 1", timer_irq); end
  endtask

  task automatic test_timer();
    drive(AStatus, 32'h1, 1'b1, 1'b0, 1'b0);
    drive(ACycle, 32'd100, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %b want 0", timer_irq); end
    drive(ATimer, 32'd105, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (timer_irq !== 1'b0) begin
        n_err++;
        $display("FAIL irq_early[%0d]: got %b want 0", i, timer_irq);
      end
    end
    rdq.push_back(32'h3);
    drive(AStatus, 32'h0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b1) begin n_err++; $display("FAIL irq_match: got %b want 1", timer_irq); end
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL status_pending: got %h want %h", ddata_r, exp_v); end
    rdq.push_back(32'd105);
    drive(ATimer, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL timer_cmp_read: got %h want %h", ddata_r, exp_v); end
    // Re-hit the compare while pending is set and clear on the hit cycle.
    drive(ACycle, 32'd103, 1'b1, 1'b0, 1'b0);
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(AStatus, 32'h1, 1'b1, 1'b0, 1'b0);
    drive(AStatus, 32'h1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b1) begin n_err++; $display("FAIL w1c_collision: got %b want 1", timer_irq); end
    drive(ACycle, 32'd105, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b0) begin n_err++; $display("FAIL w1c_clear: got %b want 0", timer_irq); end
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b0) begin n_err++; $display("FAIL cycle_write_cmp: got %b want 0", timer_irq); end
    drive(AStatus, 32'h1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b1) begin n_err++; $display("FAIL loaded_cmp: got %b want 1", timer_irq); end
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b0) begin n_err++; $display("FAIL final_clear: got %b want 0", timer_irq); end
  endtask

  task automatic test_drain();
    int budget;
    budget = 20;
    for (int i = 0; i < budget; i++) begin
      drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      if (dbg_valid === 1'b1) begin
        n_cmp++;
        if (fifoq.size() == 0) begin
          n_err++;
          $display("FAIL drain_extra: got %h want no data", dbg_data);
        end else begin
          exp_v = fifoq.pop_front();
          if (dbg_data !== exp_v) begin
            n_err++;
            $display("FAIL drain_order: got %h want %h", dbg_data, exp_v);
          end
        end
      end else if (fifoq.size() == 0) begin
        break;
      end
    end
    n_cmp++;
    if (fifoq.size() != 0 || dbg_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_done: got %0d left valid=%b want 0 left valid=0", fifoq.size(),
               dbg_valid);
    end
    fifoq.delete();
  endtask

  task automatic test_fifo_fill();
    for (int i = 1; i <= 8; i++) begin
      drive(AConsole, 32'(i), 1'b1, 1'b0, 1'b0);
      fifoq.push_back(32'(i));
    end
    rdq.push_back(32'h4);
    rdq.push_back(32'd8);
    drive(AStatus, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL status_full: got %h want %h", ddata_r, exp_v); end
    drive(AConsole, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL console_count: got %h want %h", ddata_r, exp_v); end
    drive(AConsole, 32'h9, 1'b1, 1'b0, 1'b0);
    rdq.push_back(32'hC);
    drive(AStatus, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL status_ovf: got %h want %h", ddata_r, exp_v); end
    test_drain();
    drive(AStatus, 32'h8, 1'b1, 1'b0, 1'b0);
    rdq.push_back(32'h2);
    drive(AStatus, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL ovf_clear: got %h want %h", ddata_r, exp_v); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 8; i++) begin
      drive(AConsole, 32'h20 + 32'(i), 1'b1, 1'b0, 1'b0);
      fifoq.push_back(32'h20 + 32'(i));
    end
    drive(AConsole, 32'hA, 1'b1, 1'b0, 1'b1);
    exp_v = fifoq.pop_front();
    fifoq.push_back(32'hA);
    n_cmp++;
    if (dbg_data !== exp_v) begin n_err++; $display("FAIL full_pop_head: got %h want %h", dbg_data, exp_v); end
    rdq.push_back(32'h4);
    drive(AStatus, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL full_pop_status: got %h want %h", ddata_r, exp_v); end
    test_drain();
  endtask

  task automatic test_empty_push();
    drive(AConsole, 32'h55, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL empty_no_ft: got %b want 0", dbg_valid); end
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dbg_valid !== 1'b1 || dbg_data !== 32'h55) begin
      n_err++;
      $display("FAIL empty_push: got v=%b %h want v=1 00000055", dbg_valid, dbg_data);
    end
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL empty_after_pop: got %b want 0", dbg_valid); end
    drive(AConsole, 32'h66, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (dbg_valid !== 1'b1 || dbg_data !== 32'h66) begin
        n_err++;
        $display("FAIL head_hold[%0d]: got v=%b %h want v=1 00000066", i, dbg_valid, dbg_data);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(ACycle, 32'd500, 1'b1, 1'b0, 1'b0);
    drive(ATimer, 32'd501, 1'b1, 1'b0, 1'b0);
    drive(AConsole, 32'h77, 1'b1, 1'b0, 1'b0);
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (timer_irq !== 1'b1 || dbg_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got irq=%b v=%b want 1 1", timer_irq, dbg_valid);
    end
    drive(10'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (dbg_valid !== 1'b0 || timer_irq !== 1'b0 || dbg_data !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b irq=%b %h want 0 0 0", dbg_valid, timer_irq, dbg_data);
    end
    daddr = ACycle;
    mem_read = 1'b1;
    rdq.push_back(32'h0);
    #1;
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL reset_cycle: got %h want %h", ddata_r, exp_v); end
    daddr = ATimer;
    rdq.push_back(32'hFFFF_FFFF);
    #1;
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL reset_tcmp: got %h want %h", ddata_r, exp_v); end
    @(negedge CLK);
    RESET_N = 1'b1;
    daddr = ACycle;
    rdq.push_back(32'h0);
    #1;
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL release_cycle: got %h want %h", ddata_r, exp_v); end
    rdq.push_back(32'h2);
    drive(AStatus, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_v = rdq.pop_front();
    n_cmp++;
    if (ddata_r !== exp_v) begin n_err++; $display("FAIL release_status: got %h want %h", ddata_r, exp_v); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_cycle();
    test_timer();
    test_fifo_fill();
    test_full_push_pop();
    test_empty_push();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
